wb_classic_arbiter: RTL and testbench
=====================================

WB_CLASSIC_ARBITER -- requirements
Module: wb_classic_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  NUM_CTRL 2 number of Wishbone classic controllers sharing one device (2..8).
  DAT_WIDTH 8 data bus width.
  TIMEOUT_CYCLES 16 wait-state limit before abort; 0 disables the watchdog.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk_i input 1 single clock; all logic on posedge.
  rst_ni input 1 reset, asynchronous, active-low.
  c_cyc_i input NUM_CTRL per-controller cyc.
  c_stb_i input NUM_CTRL per-controller stb.
  c_we_i input NUM_CTRL per-controller we.
  c_dat_i input NUM_CTRL*DAT_WIDTH per-controller write data, controller k at bits [k*DAT_WIDTH +: DAT_WIDTH].
  c_ack_o output NUM_CTRL per-controller ack.
  c_err_o output NUM_CTRL per-controller err.
  c_rty_o output NUM_CTRL per-controller rty.
  c_dat_o output DAT_WIDTH read data, broadcast to all controllers.
  d_cyc_o, d_stb_o, d_we_o output 1 each, to the device.
  d_dat_o output DAT_WIDTH write data to the device.
  d_ack_i, d_err_i, d_rty_i input 1 each, from the device.
  d_dat_i input DAT_WIDTH read data from the device.
  grant_o output NUM_CTRL one-hot current owner; all zero when idle.
  timeout_o output 1 one-cycle pulse on watchdog abort.

Function
REQ-003 The FSM SHALL have states IDLE, GRANTED and ABORT.
REQ-004 In IDLE, when any c_cyc_i bit is 1, the block SHALL select the owner round-robin, starting the search at last_owner+1 modulo NUM_CTRL, and enter GRANTED on the next edge; grant latency SHALL be exactly 1 cycle.
REQ-005 In IDLE, d_cyc_o, d_stb_o, all c_ack_o/c_err_o/c_rty_o and grant_o SHALL be 0.
REQ-006 In GRANTED, d_cyc_o/d_stb_o/d_we_o/d_dat_o SHALL combinationally equal the owner's inputs.
REQ-007 In GRANTED, d_ack_i/d_err_i/d_rty_i SHALL be routed combinationally to the owner only; non-owners SHALL see 0.
REQ-008 c_dat_o SHALL equal d_dat_i in every state.
REQ-009 The grant SHALL be held while the owner's c_cyc_i is 1, including back-to-back cycles after ack (bus lock).
REQ-010 In GRANTED, when the owner's c_cyc_i is 0, the block SHALL enter IDLE, set last_owner to the owner, and forward d_cyc_o=0 in that cycle.
REQ-011 Requests from non-owners SHALL be ignored until the arbiter returns to IDLE; no grant change SHALL occur mid-cycle.
REQ-012 The watchdog counter (width clog2(TIMEOUT_CYCLES+1)) SHALL increment each GRANTED cycle in which d_cyc_o&&d_stb_o is 1 and d_ack_i/d_err_i/d_rty_i are all 0, and SHALL clear otherwise.
REQ-013 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL enter ABORT on the next edge.
REQ-014 In ABORT, which lasts exactly one cycle, d_cyc_o and d_stb_o SHALL be 0, and c_err_o of the owner and timeout_o SHALL be 1.
REQ-015 ABORT SHALL exit to GRANTED if the owner's c_cyc_i is still 1, else to IDLE with last_owner updated.
REQ-016 With TIMEOUT_CYCLES=0 the counter SHALL be held at 0 and ABORT SHALL be unreachable.
REQ-017 A device response arriving in the same cycle the counter hits the limit SHALL win: no abort, and the counter clears.

Reset
REQ-018 While rst_ni=0, the block SHALL be in IDLE with the watchdog at 0, last_owner=NUM_CTRL-1 (so controller 0 wins first), and all outputs 0 except c_dat_o=d_dat_i.
REQ-019 Reset asserted mid-transfer SHALL drop d_cyc_o immediately (asynchronously), without an err pulse.

Structure
REQ-020 A package wb_arb_pkg SHALL hold the state enum (IDLE, GRANTED, ABORT) and the NUM_CTRL width helper.
REQ-021 A combinational sub-module wb_rr_picker SHALL take (req vector, last_owner) and return a one-hot grant plus an index.

Verification
REQ-022 Reset release, c_cyc_i=2'b11 -> grant_o=2'b01 one cycle later; after ctrl0 drops cyc, grant_o=2'b10 within 2 cycles.
REQ-023 Ctrl1 write with dat 8'hA5 and device ack after 3 wait states -> d_dat_o=8'hA5 throughout, c_ack_o=2'b10 for one cycle, c_ack_o[0]=0 always.
REQ-024 Ctrl0 holds cyc across two acked transfers while ctrl1 requests -> grant_o stays 2'b01 until ctrl0 cyc=0.
REQ-025 TIMEOUT_CYCLES=4 with device never responding -> timeout_o and c_err_o[owner] pulse exactly once; d_cyc_o=0 in that cycle.
REQ-026 rst_ni low mid-transfer -> d_cyc_o=0 and grant_o=0 before the next edge; after release, ctrl0 has priority.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and sizing helpers for the Wishbone classic arbiter.
package wb_arb_pkg;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      ABORT   = 2'd2
   } arb_state_e;

   // Width of a controller index. It is never narrower than one bit.
   function automatic int idx_width(input int num_ctrl);
      return (num_ctrl > 1) ? $clog2(num_ctrl) : 1;
   endfunction

   // Width of the watchdog counter. It can hold the value timeout itself.
   function automatic int wd_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin request picker. The search starts one position past
// last_owner and wraps modulo NUM_CTRL. Returns a one-hot grant and its
// index. Both outputs are zero when no request is present.
module wb_rr_picker
   import wb_arb_pkg::*;
#(
   parameter int NUM_CTRL = 2,
   parameter int IDX_W    = idx_width(NUM_CTRL)
) (
   input  logic [NUM_CTRL-1:0] req,
   input  logic [IDX_W-1:0]    last_owner,
   output logic [NUM_CTRL-1:0] grant,
   output logic [IDX_W-1:0]    index
);

   int   cand;
   logic found;

   // Walk candidates last_owner+1 ... last_owner+NUM_CTRL and take the first requester.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      grant = '0;
      index = '0;
      found = 1'b0;
      cand  = 0;
      for (int i = 1; i <= NUM_CTRL; i++) begin
         cand = int'(last_owner) + i;
         if (cand >= NUM_CTRL) cand = cand - NUM_CTRL;
         for (int k = 0; k < NUM_CTRL; k++) begin
            if (!found && (k == cand) && req[k]) begin
               found    = 1'b1;
               grant[k] = 1'b1;
               index    = IDX_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/wb_classic_arbiter.sv
// Wishbone classic arbiter. Several controllers share one device.
// Ownership is granted round-robin and then held for the whole bus cycle.
// A watchdog aborts transfers that the device never answers.
module wb_classic_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_CTRL       = 2,
   parameter int DAT_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_CTRL-1:0]           c_cyc_i,
   input  logic [NUM_CTRL-1:0]           c_stb_i,
   input  logic [NUM_CTRL-1:0]           c_we_i,
   input  logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i,
   output logic [NUM_CTRL-1:0]           c_ack_o,
   output logic [NUM_CTRL-1:0]           c_err_o,
   output logic [NUM_CTRL-1:0]           c_rty_o,
   output logic [DAT_WIDTH-1:0]          c_dat_o,
   output logic                          d_cyc_o,
   output logic                          d_stb_o,
   output logic                          d_we_o,
   output logic [DAT_WIDTH-1:0]          d_dat_o,
   input  logic                          d_ack_i,
   input  logic                          d_err_i,
   input  logic                          d_rty_i,
   input  logic [DAT_WIDTH-1:0]          d_dat_i,
   output logic [NUM_CTRL-1:0]           grant_o,
   output logic                          timeout_o
);

   localparam int                IDX_W    = idx_width(NUM_CTRL);
   localparam int                WD_W     = wd_width(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_CTRL - 1);

   arb_state_e           state_q, state_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [WD_W-1:0]      wd_q, wd_d;

   logic [NUM_CTRL-1:0]  pick_gnt;
   logic [IDX_W-1:0]     pick_idx;

   logic                 own_cyc, own_stb, own_we;
   logic [DAT_WIDTH-1:0] own_dat;
   logic [NUM_CTRL-1:0]  owner_oh;
   logic                 stall;

   wb_rr_picker #(
      .NUM_CTRL (NUM_CTRL),
      .IDX_W    (IDX_W)
   ) u_picker (
      .req        (c_cyc_i),
      .last_owner (last_q),
      .grant      (pick_gnt),
      .index      (pick_idx)
   );

   // Select the current owner's request signals and decode its one-hot position.
   always_comb begin
      own_cyc  = 1'b0;
      own_stb  = 1'b0;
      own_we   = 1'b0;
      own_dat  = '0;
      owner_oh = '0;
      for (int k = 0; k < NUM_CTRL; k++) begin
         if (owner_q == IDX_W'(k)) begin
            own_cyc     = c_cyc_i[k];
            own_stb     = c_stb_i[k];
            own_we      = c_we_i[k];
            own_dat     = c_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
            owner_oh[k] = 1'b1;
         end
      end
   end

   // Drive the device and the controller responses from the current state.
   always_comb begin
      d_cyc_o   = 1'b0;
      d_stb_o   = 1'b0;
      d_we_o    = 1'b0;
      d_dat_o   = '0;
      c_ack_o   = '0;
      c_err_o   = '0;
      c_rty_o   = '0;
      grant_o   = '0;
      timeout_o = 1'b0;
      c_dat_o   = d_dat_i;
      case (state_q)
         GRANTED: begin
            d_cyc_o = own_cyc;
            d_stb_o = own_stb;
            d_we_o  = own_we;
            d_dat_o = own_dat;
            c_ack_o = owner_oh & {NUM_CTRL{d_ack_i}};
            c_err_o = owner_oh & {NUM_CTRL{d_err_i}};
            c_rty_o = owner_oh & {NUM_CTRL{d_rty_i}};
            grant_o = owner_oh;
         end
         ABORT: begin
            c_err_o   = owner_oh;
            grant_o   = owner_oh;
            timeout_o = 1'b1;
         end
         default: ;
      endcase
   end

   // The device is being strobed and has not answered in this cycle.
   assign stall = d_cyc_o && d_stb_o && !d_ack_i && !d_err_i && !d_rty_i;

   // Next-state logic covers arbitration, the bus lock, the watchdog abort and release.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      wd_d    = '0;
      case (state_q)
         IDLE: begin
            if (|pick_gnt) begin
               state_d = GRANTED;
               owner_d = pick_idx;
            end
         end
         GRANTED: begin
            if (!own_cyc) begin
               state_d = IDLE;
               last_d  = owner_q;
            end else if ((TIMEOUT_CYCLES != 0) && stall && (wd_q == WD_LIMIT)) begin
               state_d = ABORT;
            end else if ((TIMEOUT_CYCLES != 0) && stall) begin
               wd_d = wd_q + 1'b1;
            end
         end
         ABORT: begin
            if (own_cyc) begin
               state_d = GRANTED;
            end else begin
               state_d = IDLE;
               last_d  = owner_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, ownership and watchdog registers. Reset favours controller 0 first.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= LAST_RST;
         wd_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
      end
   end

endmodule

// File: tb/tb_wb_classic_arbiter.sv
// Directed bench for wb_classic_arbiter. Two controllers and 8-bit data are used.
// The main instance has a 4-cycle watchdog. A second instance has the
// watchdog disabled and receives the same stimulus.
module tb_wb_classic_arbiter;

   localparam int N  = 2;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    c_cyc, c_stb, c_we;
   logic [N*DW-1:0] c_dat_i;
   logic            d_ack, d_err, d_rty;
   logic [DW-1:0]   d_dat_i;

   logic [N-1:0]    c_ack, c_err, c_rty, grant;
   logic [DW-1:0]   c_dat_o, d_dat_o;
   logic            d_cyc, d_stb, d_we, timeout;

   logic [N-1:0]    nt_c_ack, nt_c_err, nt_c_rty, nt_grant;
   logic [DW-1:0]   nt_c_dat_o, nt_d_dat_o;
   logic            nt_d_cyc, nt_d_stb, nt_d_we, nt_timeout;

   int n_pass   = 0;
   int n_checks = 0;

   always #5 clk = ~clk;

   wb_classic_arbiter #(.NUM_CTRL(N), .DAT_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .c_cyc_i(c_cyc), .c_stb_i(c_stb), .c_we_i(c_we), .c_dat_i(c_dat_i),
      .c_ack_o(c_ack), .c_err_o(c_err), .c_rty_o(c_rty), .c_dat_o(c_dat_o),
      .d_cyc_o(d_cyc), .d_stb_o(d_stb), .d_we_o(d_we), .d_dat_o(d_dat_o),
      .d_ack_i(d_ack), .d_err_i(d_err), .d_rty_i(d_rty), .d_dat_i(d_dat_i),
      .grant_o(grant), .timeout_o(timeout)
   );

   wb_classic_arbiter #(.NUM_CTRL(N), .DAT_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_nt (
      .clk_i(clk), .rst_ni(rst_n),
      .c_cyc_i(c_cyc), .c_stb_i(c_stb), .c_we_i(c_we), .c_dat_i(c_dat_i),
      .c_ack_o(nt_c_ack), .c_err_o(nt_c_err), .c_rty_o(nt_c_rty), .c_dat_o(nt_c_dat_o),
      .d_cyc_o(nt_d_cyc), .d_stb_o(nt_d_stb), .d_we_o(nt_d_we), .d_dat_o(nt_d_dat_o),
      .d_ack_i(d_ack), .d_err_i(d_err), .d_rty_i(d_rty), .d_dat_i(d_dat_i),
      .grant_o(nt_grant), .timeout_o(nt_timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Inputs change 2 time units after the rising edge. Outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int at_cycle;
      int extra_pulses;
      int nt_pulses;

      rst_n   = 1'b0;
      c_cyc   = '0;
      c_stb   = '0;
      c_we    = '0;
      c_dat_i = '0;
      d_ack   = 1'b0;
      d_err   = 1'b0;
      d_rty   = 1'b0;
      d_dat_i = 8'h3C;

      // Reset state: every output is 0, and read data passes straight through.
      #3;
      check("rst_grant",   grant,   2'b00);
      check("rst_d_cyc",   d_cyc,   1'b0);
      check("rst_c_ack",   c_ack,   2'b00);
      check("rst_c_err",   c_err,   2'b00);
      check("rst_timeout", timeout, 1'b0);
      check("rst_c_dat",   c_dat_o, 8'h3C);

      // Both controllers request while reset is held. Ctrl0 wins one edge after release.
      c_cyc = 2'b11;
      tick();
      check("rst_hold_grant", grant, 2'b00);
      rst_n = 1'b1;
      #1 check("grant_latency_0", grant, 2'b00);
      tick();
      check("first_grant", grant, 2'b01);
      check("first_d_cyc", d_cyc, 1'b1);
      c_cyc = 2'b10;
      #1 check("drop_fwd_d_cyc", d_cyc, 1'b0);
      tick();
      check("idle_between", grant, 2'b00);
      tick();
      check("handover_ctrl1", grant, 2'b10);
      c_cyc = 2'b00;
      tick();

      // Ctrl1 writes A5. The device inserts 3 wait states and then acks.
      c_cyc   = 2'b10;
      c_stb   = 2'b10;
      c_we    = 2'b10;
      c_dat_i = 16'hA55A;
      tick();
      for (int w = 0; w < 3; w++) begin
         #1;
         check("wr_d_dat", d_dat_o, 8'hA5);
         check("wr_d_we",  d_we,    1'b1);
         check("wr_wait_ack", c_ack, 2'b00);
         tick();
      end
      d_ack = 1'b1;
      #1;
      check("wr_ack",       c_ack,   2'b10);
      check("wr_d_dat_ack", d_dat_o, 8'hA5);
      d_dat_i = 8'h77;
      #1 check("rd_passthru", c_dat_o, 8'h77);
      tick();
      d_ack = 1'b0;
      c_cyc = 2'b00;
      c_stb = 2'b00;
      c_we  = 2'b00;
      #1;
      check("wr_ack_done", c_ack, 2'b00);
      check("wr_release",  d_cyc, 1'b0);
      tick();

      // Ctrl0 holds cyc across two acked transfers while ctrl1 also requests.
      c_cyc = 2'b11;
      c_stb = 2'b11;
      tick();
      d_ack = 1'b1;
      #1;
      check("lock_ack1",   c_ack, 2'b01);
      check("lock_grant1", grant, 2'b01);
      tick();
      d_ack = 1'b0;
      #1 check("lock_gap", grant, 2'b01);
      tick();
      d_ack = 1'b1;
      #1 check("lock_ack2", c_ack, 2'b01);
      tick();
      d_ack = 1'b0;
      c_cyc = 2'b10;
      c_stb = 2'b10;
      #1;
      check("lock_last", grant, 2'b01);
      check("lock_drop", d_cyc, 1'b0);
      tick();
      check("lock_idle", grant, 2'b00);
      tick();
      check("lock_next", grant, 2'b10);
      c_cyc = 2'b00;
      c_stb = 2'b00;
      tick();

      // Boundary case. The ack arrives in the cycle the counter sits at the limit, so the ack wins.
      c_cyc = 2'b01;
      c_stb = 2'b01;
      tick();
      for (int i = 0; i < 4; i++) begin
         #1 check("edge_no_to", timeout, 1'b0);
         tick();
      end
      d_ack = 1'b1;
      #1;
      check("edge_ack",   c_ack,   2'b01);
      check("edge_no_to", timeout, 1'b0);
      tick();
      d_ack = 1'b0;
      c_cyc = 2'b00;
      c_stb = 2'b00;
      #1;
      check("edge_no_abort", timeout, 1'b0);
      check("edge_no_err",   c_err,   2'b00);
      tick();

      // Watchdog case. Ctrl1 strobes and the device never answers.
      // There are 4 counting cycles, then one cycle at the limit, then the ABORT cycle.
      c_cyc     = 2'b10;
      c_stb     = 2'b10;
      at_cycle  = 0;
      nt_pulses = 0;
      tick();
      for (int k = 1; k <= 20; k++) begin
         #1;
         if (nt_timeout) nt_pulses++;
         if (timeout) begin
            at_cycle = k;
            check("abort_d_cyc", d_cyc, 1'b0);
            check("abort_err",   c_err, 2'b10);
            break;
         end
         tick();
      end
      check("abort_cycle", at_cycle, 6);
      tick();
      check("abort_regrant",  grant,   2'b10);
      check("abort_one_shot", timeout, 1'b0);
      check("abort_d_cyc_back", d_cyc, 1'b1);
      c_cyc = 2'b00;
      c_stb = 2'b00;
      extra_pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         #1;
         if (timeout) extra_pulses++;
         if (nt_timeout) nt_pulses++;
      end
      check("abort_once",  extra_pulses, 0);
      check("wd_disabled", nt_pulses,    0);

      // Reset mid-transfer. The bus drops at once with no err. Ctrl0 has priority afterwards.
      c_cyc = 2'b10;
      c_stb = 2'b10;
      tick();
      c_cyc = 2'b11;
      c_stb = 2'b11;
      #1 check("pre_rst_grant", grant, 2'b10);
      rst_n = 1'b0;
      #1;
      check("async_d_cyc", d_cyc,   1'b0);
      check("async_grant", grant,   2'b00);
      check("async_err",   c_err,   2'b00);
      check("async_to",    timeout, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_prio", grant, 2'b01);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
